ysyx_22041405_core_ctrl: RTL and testbench
==========================================

Name: ysyx_22041405_core_ctrl

Overview:
Multi-cycle sequencer for the RV32 core. Owns PC and IR, fetches instructions over a valid/ready instruction-memory port and holds IR stable for the combinational decoder. It then steps each instruction through decode, execute, optional memory access and write-back, gating register-file writes and PC updates. It also stops the core on ebreak, illegal instruction or misaligned next PC, and counts retired instructions.

Parameters:
WIDTH, 32, data/address width
RESET_PC, 32'h8000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, IR value on reset (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  fetch request accepted
imem_addr  out  WIDTH  fetch address (= pc)
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  WIDTH  fetched instruction
dmem_req_valid  out  1  load/store request valid
dmem_req_ready  in  1  load/store request accepted
dmem_we  out  1  1 = store, 0 = load
dmem_rsp_valid  in  1  load data / store ack valid
dec_rf_we  in  1  decoder: instruction writes rd
dec_is_load  in  1  decoder: load class
dec_is_store  in  1  decoder: store class
dec_is_ebreak  in  1  decoder: ebreak
dec_illegal  in  1  decoder: unrecognised encoding
next_pc  in  WIDTH  datapath-computed next PC
pc  out  WIDTH  current PC (registered)
ir  out  WIDTH  current instruction to decoder (registered)
rf_we  out  1  register-file write strobe
pc_we  out  1  PC update strobe (debug/trace)
halt  out  1  core stopped (sticky)
halt_code  out  2  0 ebreak, 1 illegal, 2 misaligned PC
instret  out  64  retired-instruction counter

Behaviour:
- Reset, async on rst_n low:
  - state = FETCH_REQ, pc = RESET_PC, ir = NOP_INSTR.
  - halt = 0, halt_code = 0, instret = 0.
  - All strobes drop combinationally.
- Strobes are Moore outputs decoded from state. pc, ir, halt, halt_code and instret are registers.
- States and transitions:
  - FETCH_REQ: imem_req_valid = 1, imem_addr = pc. Valid and addr are held until imem_req_ready=1, then go to FETCH_WAIT.
  - FETCH_WAIT: when imem_rsp_valid=1, ir <= imem_rsp_data and go to DECODE. A response is never accepted in the same cycle as its request.
  - DECODE: one settle cycle for decoder and register-file read.
    - dec_illegal=1 → HALT, code 1.
    - dec_is_ebreak=1 → HALT, code 0.
    - Otherwise → EXEC.
    - If both illegal and ebreak are set, illegal wins.
  - EXEC: one ALU/address settle cycle. Load or store → MEM_REQ; otherwise → WB.
  - MEM_REQ: dmem_req_valid = 1, dmem_we = dec_is_store, both held until dmem_req_ready=1, then go to MEM_WAIT.
  - MEM_WAIT: when dmem_rsp_valid=1 go to WB.
  - WB:
    - If next_pc[1:0] != 0: HALT with code 2; pc unchanged, no rf_we, no retire.
    - Otherwise, in this cycle only:
      - rf_we = dec_rf_we & ~dec_is_store;
      - pc_we = 1, pc <= next_pc;
      - instret += 1 (wraps modulo 2^64);
      - go to FETCH_REQ.
  - HALT: halt = 1, no requests, no strobes. Stays here until reset.
- Latency: a non-memory instruction takes 5 cycles with zero-wait memory (FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB). A load or store takes 7.
- Because ir is stable from DECODE through WB, the decoder inputs are valid throughout.
- Responses arriving in any state other than the matching WAIT state are ignored. This includes stale responses after a mid-transaction reset; the memory side must drop pending requests on reset.
- rf_we and pc_we are never high outside WB. At most one memory request is outstanding at any time.

Decomposition:
- Shared package ysyx_22041405_defs holds:
  - state encoding localparams (FETCH_REQ..HALT, 3 bits);
  - HALT_EBREAK / HALT_ILLEGAL / HALT_MISALIGN codes;
  - RESET_PC and NOP_INSTR constants;
  - opcode constants also used by the decoder.
- One sub-module: ysyx_22041405_instret_cnt, a 64-bit counter with an increment enable.

Test Plan:
- Reset then release, imem ready/rsp with zero wait, rsp_data=0x00500093 (addi x1,x0,5), next_pc=0x80000004 → imem_addr=0x80000000; rf_we pulses 1 cycle in cycle 5; pc=0x80000004; instret=1.
- imem_req_ready held low 3 cycles → imem_req_valid stays 1 with addr stable; accepted on the 4th cycle; no extra request.
- Load instruction (dec_is_load=1, dec_rf_we=1), dmem_rsp_valid delayed 2 cycles → dmem_we=0; rf_we only in WB after the response. Same with store (dec_is_store=1, dec_rf_we=1) → dmem_we=1, rf_we=0, instret still increments.
- Fetch 0x00100073 with dec_is_ebreak=1 → halt=1, halt_code=0 after DECODE; no further imem_req_valid over 20 cycles; pc unchanged.
- dec_illegal=1 → halt_code=1. Separately, next_pc=0x80000006 in WB → halt_code=2, rf_we=0, instret unchanged.
- Assert rst_n low while in MEM_WAIT, then inject a stale dmem_rsp_valid after release → state FETCH_REQ, pc=0x80000000, instret=0, stale response ignored.

Source files
------------

// File: rtl/ysyx_22041405_core_ctrl_pkg.sv
// Shared constants for the RV32 multi-cycle core:
// sequencer state encoding, halt causes, reset values and opcodes.
package ysyx_22041405_defs;

  localparam logic [2:0] FETCH_REQ  = 3'd0;
  localparam logic [2:0] FETCH_WAIT = 3'd1;
  localparam logic [2:0] DECODE     = 3'd2;
  localparam logic [2:0] EXEC       = 3'd3;
  localparam logic [2:0] MEM_REQ    = 3'd4;
  localparam logic [2:0] MEM_WAIT   = 3'd5;
  localparam logic [2:0] WB         = 3'd6;
  localparam logic [2:0] HALT       = 3'd7;

  localparam logic [1:0] HALT_EBREAK   = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL  = 2'd1;
  localparam logic [1:0] HALT_MISALIGN = 2'd2;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  function automatic logic pc_misaligned(
    input logic [1:0] lsb
  );
    return |lsb;
  endfunction

endpackage

// File: rtl/ysyx_22041405_core_ctrl_if.sv
// Instruction- and data-memory valid/ready port
// between the core sequencer and the memory side.
interface ysyx_22041405_core_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;

  logic             dmem_req_valid;
  logic             dmem_req_ready;
  logic             dmem_we;
  logic             dmem_rsp_valid;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dmem_req_valid,
    output dmem_we,
    input  dmem_req_ready,
    input  dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dmem_req_valid,
    input  dmem_we,
    output dmem_req_ready,
    output dmem_rsp_valid
  );

endinterface

// File: rtl/ysyx_22041405_instret_cnt.sv
// 64-bit retired-instruction counter, wraps modulo 2^64.
module ysyx_22041405_instret_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22041405_core_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, steps fetch, decode,
// execute, memory and write-back, and halts on faults.
module ysyx_22041405_core_ctrl
  import ysyx_22041405_defs::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  =
    ysyx_22041405_defs::RESET_PC,
  parameter logic [WIDTH-1:0] NOP_INSTR =
    ysyx_22041405_defs::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  ysyx_22041405_core_ctrl_if.master bus,
  input  logic             dec_rf_we,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_ebreak,
  input  logic             dec_illegal,
  input  logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [63:0]      instret
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] code_nxt;
  logic       in_wb;
  logic       wb_ok;
  logic       to_halt;

  assign in_wb = (state == WB);
  assign wb_ok = in_wb && !pc_misaligned(next_pc[1:0]);

  always_comb begin
    state_nxt = state;
    code_nxt  = halt_code;
    case (state)
      FETCH_REQ: begin
        if (bus.imem_req_ready) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (bus.imem_rsp_valid) state_nxt = DECODE;
      end
      DECODE: begin
        // illegal outranks ebreak when both flags are raised
        if (dec_illegal) begin
          state_nxt = HALT;
          code_nxt  = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          state_nxt = HALT;
          code_nxt  = HALT_EBREAK;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (dec_is_load || dec_is_store) begin
          state_nxt = MEM_REQ;
        end else begin
          state_nxt = WB;
        end
      end
      MEM_REQ: begin
        if (bus.dmem_req_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.dmem_rsp_valid) state_nxt = WB;
      end
      WB: begin
        if (wb_ok) begin
          state_nxt = FETCH_REQ;
        end else begin
          state_nxt = HALT;
          code_nxt  = HALT_MISALIGN;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  assign to_halt = (state_nxt == HALT) && (state != HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_REQ;
      pc        <= RESET_PC;
      ir        <= NOP_INSTR;
      halt      <= 1'b0;
      halt_code <= HALT_EBREAK;
    end else begin
      state <= state_nxt;
      if (state == FETCH_WAIT && bus.imem_rsp_valid) begin
        ir <= bus.imem_rsp_data;
      end
      if (wb_ok) begin
        pc <= next_pc;
      end
      if (to_halt) begin
        halt      <= 1'b1;
        halt_code <= code_nxt;
      end
    end
  end

  // strobes are forced low while reset is held
  assign bus.imem_req_valid = rst_n && (state == FETCH_REQ);
  assign bus.imem_addr      = pc;
  assign bus.dmem_req_valid = rst_n && (state == MEM_REQ);
  assign bus.dmem_we        = rst_n && (state == MEM_REQ)
                              && dec_is_store;

  assign rf_we = rst_n && wb_ok && dec_rf_we && !dec_is_store;
  assign pc_we = rst_n && wb_ok;

  ysyx_22041405_instret_cnt u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wb_ok),
    .count (instret)
  );

endmodule

// File: tb/tb_ysyx_22041405_core_ctrl.sv
// Directed bench for the core sequencer: fetch, memory
// handshakes, halts and mid-transaction reset.
module tb_ysyx_22041405_core_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_rf_we;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_ebreak;
  logic        dec_illegal;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic [1:0]  halt_code;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;
  int reqs;

  ysyx_22041405_core_ctrl_if #(.WIDTH(32)) bus ();

  ysyx_22041405_core_ctrl #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .dec_rf_we     (dec_rf_we),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_ebreak (dec_is_ebreak),
    .dec_illegal   (dec_illegal),
    .next_pc       (next_pc),
    .pc            (pc),
    .ir            (ir),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .halt          (halt),
    .halt_code     (halt_code),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    dec_rf_we     = 1'b0;
    dec_is_load   = 1'b0;
    dec_is_store  = 1'b0;
    dec_is_ebreak = 1'b0;
    dec_illegal   = 1'b0;
    next_pc       = 32'h8000_0004;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_ir", ir, 64'h13);
    chk("rst_halt", halt, 0);
    chk("rst_code", halt_code, 0);
    chk("rst_instret", instret, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_ireq", bus.imem_req_valid, 0);
    rst_n = 1'b1;

    // addi x1,x0,5 with zero-wait memory
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0050_0093;
    dec_rf_we = 1'b1;
    next_pc   = 32'h8000_0004;
    #1;
    chk("c1_ireq", bus.imem_req_valid, 1);
    chk("c1_addr", bus.imem_addr, 64'h8000_0000);
    chk("c1_rf_we", rf_we, 0);
    tick();
    chk("c2_ireq", bus.imem_req_valid, 0);
    chk("c2_rf_we", rf_we, 0);
    tick();
    chk("c3_ir", ir, 64'h0050_0093);
    chk("c3_rf_we", rf_we, 0);
    tick();
    chk("c4_rf_we", rf_we, 0);
    tick();
    chk("c5_rf_we", rf_we, 1);
    chk("c5_pc_we", pc_we, 1);
    chk("c5_pc", pc, 64'h8000_0000);
    tick();
    chk("c6_rf_we", rf_we, 0);
    chk("c6_pc", pc, 64'h8000_0004);
    chk("c6_instret", instret, 1);
    chk("c6_addr", bus.imem_addr, 64'h8000_0004);

    // fetch backpressure: ready low for 3 cycles
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ireq", bus.imem_req_valid, 1);
      chk("bp_addr", bus.imem_addr, 64'h8000_0004);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    chk("bp_acc", bus.imem_req_valid, 0);

    // load with response delayed 2 cycles
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_2103;
    dec_is_load = 1'b1;
    next_pc     = 32'h8000_0008;
    tick();
    chk("ld_ir", ir, 64'h0000_2103);
    chk("ld_noreq", bus.imem_req_valid, 0);
    tick();
    tick();
    chk("ld_dreq", bus.dmem_req_valid, 1);
    chk("ld_we", bus.dmem_we, 0);
    tick();
    chk("ld_dreq_hold", bus.dmem_req_valid, 1);
    bus.dmem_req_ready = 1'b1;
    tick();
    chk("ld_wait_dreq", bus.dmem_req_valid, 0);
    chk("ld_wait_rf", rf_we, 0);
    tick();
    tick();
    chk("ld_wait2_rf", rf_we, 0);
    bus.dmem_rsp_valid = 1'b1;
    #1;
    chk("ld_rsp_rf", rf_we, 0);
    tick();
    chk("ld_wb_rf", rf_we, 1);
    chk("ld_wb_pcwe", pc_we, 1);
    bus.dmem_rsp_valid = 1'b0;
    tick();
    chk("ld_pc", pc, 64'h8000_0008);
    chk("ld_instret", instret, 2);

    // store
    dec_is_load  = 1'b0;
    dec_is_store = 1'b1;
    next_pc      = 32'h8000_000C;
    bus.imem_rsp_data  = 32'h0020_a023;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("st_dreq", bus.dmem_req_valid, 1);
    chk("st_we", bus.dmem_we, 1);
    bus.dmem_rsp_valid = 1'b1;
    tick();
    tick();
    chk("st_wb_rf", rf_we, 0);
    chk("st_wb_pcwe", pc_we, 1);
    bus.dmem_rsp_valid = 1'b0;
    tick();
    chk("st_instret", instret, 3);
    chk("st_pc", pc, 64'h8000_000C);

    // ebreak
    dec_is_store  = 1'b0;
    dec_rf_we     = 1'b0;
    dec_is_ebreak = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0073;
    bus.imem_req_ready = 1'b1;
    tick();
    tick();
    chk("eb_ir", ir, 64'h0010_0073);
    chk("eb_pre_halt", halt, 0);
    tick();
    chk("eb_halt", halt, 1);
    chk("eb_code", halt_code, 0);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.imem_req_valid) reqs++;
    end
    chk("eb_noreq", reqs, 0);
    chk("eb_pc", pc, 64'h8000_000C);
    chk("eb_instret", instret, 3);

    // illegal together with ebreak: illegal wins
    do_reset();
    dec_illegal   = 1'b1;
    dec_is_ebreak = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    #1;
    chk("il_rst_halt", halt, 0);
    tick();
    tick();
    tick();
    chk("il_halt", halt, 1);
    chk("il_code", halt_code, 1);
    chk("il_instret", instret, 0);

    // misaligned next PC in WB
    do_reset();
    dec_rf_we = 1'b1;
    next_pc   = 32'h8000_0006;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("ma_wb_rf", rf_we, 0);
    chk("ma_wb_pcwe", pc_we, 0);
    chk("ma_wb_halt", halt, 0);
    tick();
    chk("ma_halt", halt, 1);
    chk("ma_code", halt_code, 2);
    chk("ma_pc", pc, 64'h8000_0000);
    chk("ma_instret", instret, 0);

    // reset during MEM_WAIT, stale response afterwards
    do_reset();
    dec_is_load = 1'b1;
    next_pc     = 32'h8000_0004;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mr_wait", bus.dmem_req_valid, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.dmem_rsp_valid = 1'b1;
    #1;
    chk("mr_ireq0", bus.imem_req_valid, 1);
    tick();
    chk("mr_ireq", bus.imem_req_valid, 1);
    chk("mr_rf", rf_we, 0);
    chk("mr_pcwe", pc_we, 0);
    tick();
    chk("mr_pc", pc, 64'h8000_0000);
    chk("mr_instret", instret, 0);
    chk("mr_halt", halt, 0);
    chk("mr_addr", bus.imem_addr, 64'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
